// File: rtl/result_bcd_disp.sv
// rtl/result_bcd_disp.sv - ALU result to four-digit seven-segment display via sequential double-dabble
module result_bcd_disp #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] bin_in,
  input  logic               err_in,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic [6:0]         seg_4,
  output logic [6:0]         seg_3,
  output logic [6:0]         seg_2,
  output logic [6:0]         seg_1
);

  localparam int         N     = 2 * WIDTH;
  localparam logic [3:0] N_CNT = 4'(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_R     = 7'h2F;

  logic [1:0]   state;
  logic [N-1:0] bin_q;
  logic [15:0]  bcd_q;
  logic [15:0]  bcd_adj;
  logic [3:0]   cnt_q;
  logic         err_q;
  logic [6:0]   nxt_4, nxt_3, nxt_2, nxt_1;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = G_BLANK;
    endcase
  endfunction

  // Add-3 correction applied before each shift keeps every nibble a valid BCD digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    nxt_4 = G_BLANK;
    nxt_3 = G_BLANK;
    nxt_2 = G_BLANK;
    nxt_1 = glyph(bcd_q[3:0]);
    if (err_q) begin
      nxt_4 = G_E;
      nxt_3 = G_R;
      nxt_2 = G_R;
      nxt_1 = G_BLANK;
    end else begin
      if (bcd_q[15:12] != 4'd0) nxt_4 = glyph(bcd_q[15:12]);
      if (bcd_q[15:8]  != 8'd0) nxt_3 = glyph(bcd_q[11:8]);
      if (bcd_q[15:4]  != 12'd0) nxt_2 = glyph(bcd_q[7:4]);
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      done  <= 1'b0;
      seg_4 <= G_BLANK;
      seg_3 <= G_BLANK;
      seg_2 <= G_BLANK;
      seg_1 <= G_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            bin_q <= bin_in;
            err_q <= err_in;
            bcd_q <= '0;
            cnt_q <= N_CNT;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state <= S_LATCH;
        end
        S_LATCH: begin
          seg_4 <= nxt_4;
          seg_3 <= nxt_3;
          seg_2 <= nxt_2;
          seg_1 <= nxt_1;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_disp.sv
// tb/tb_result_bcd_disp.sv - scoreboard bench for result_bcd_disp against an arithmetic display model
module tb_result_bcd_disp;

  localparam int WIDTH = 6;
  localparam int N     = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     bin_in = '0;
  logic             err_in = 1'b0;
  logic             load = 1'b0;
  logic             busy, done;
  logic [6:0]       seg_4, seg_3, seg_2, seg_1;

  int tests = 0;
  int fails = 0;
  logic [27:0] sb[$];
  logic [6:0]  glyph_tab [10];

  result_bcd_disp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .err_in(err_in), .load(load),
    .busy(busy), .done(done), .seg_4(seg_4), .seg_3(seg_3), .seg_2(seg_2), .seg_1(seg_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, blanking by magnitude thresholds.
  function automatic logic [27:0] model(input int v, input bit err);
    logic [6:0] s4, s3, s2, s1;
    if (err) return {7'h06, 7'h2F, 7'h2F, 7'h7F};
    s4 = (v >= 1000) ? glyph_tab[(v / 1000) % 10] : 7'h7F;
    s3 = (v >= 100)  ? glyph_tab[(v / 100) % 10]  : 7'h7F;
    s2 = (v >= 10)   ? glyph_tab[(v / 10) % 10]   : 7'h7F;
    s1 = glyph_tab[v % 10];
    return {s4, s3, s2, s1};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        check("segs", 32'({seg_4, seg_3, seg_2, seg_1}), 32'(sb.pop_front()));
      end
    end
  end

  // Called just after a negedge; leaves control at the negedge where done is seen (or after abort).
  task automatic conv(input int v, input bit err, input int ignore_at, input int rst_at);
    int i;
    bin_in = N'(v);
    err_in = err;
    load   = 1'b1;
    if (rst_at == 0) sb.push_back(model(v, err));
    @(negedge clk);
    load   = 1'b0;
    bin_in = $urandom_range(0, 4095);
    err_in = $urandom_range(0, 1);
    i = 1;
    while (1) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_segs", 32'({seg_4, seg_3, seg_2, seg_1}), 32'h0FFF_FFFF);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_abort_busy", 32'(busy), 32'd0);
        return;
      end
      check("busy", 32'(busy), 32'(i <= N + 1));
      if (done) break;
      if (i > N + 10) begin
        check("done_timeout", 32'(i), 32'(N + 2));
        return;
      end
      if (i == ignore_at) begin
        load = 1'b1;
        bin_in = N'(1);
        err_in = 1'b0;
      end
      @(negedge clk);
      load = 1'b0;
      i++;
    end
    check("latency", 32'(i), 32'(N + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    glyph_tab[0] = 7'h40; glyph_tab[1] = 7'h79; glyph_tab[2] = 7'h24; glyph_tab[3] = 7'h30;
    glyph_tab[4] = 7'h19; glyph_tab[5] = 7'h12; glyph_tab[6] = 7'h02; glyph_tab[7] = 7'h78;
    glyph_tab[8] = 7'h00; glyph_tab[9] = 7'h10;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seg_4", 32'(seg_4), 32'h7F);
    check("rst_seg_3", 32'(seg_3), 32'h7F);
    check("rst_seg_2", 32'(seg_2), 32'h7F);
    check("rst_seg_1", 32'(seg_1), 32'h7F);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    conv(4095, 0, 0, 0); @(negedge clk);
    conv(0,    0, 0, 0); @(negedge clk);
    conv(105,  0, 0, 0); @(negedge clk);
    conv(7,    0, 0, 0); @(negedge clk);
    conv(36,   1, 0, 0); @(negedge clk);
    conv(36,   0, 0, 0); @(negedge clk);
    conv(1000, 0, 0, 0); @(negedge clk);
    conv(4095, 0, 5, 0); @(negedge clk);
    // back-to-back: second load issued in the done cycle
    conv(2048, 0, 0, 0);
    conv(909,  0, 0, 0); @(negedge clk);
    conv(4095, 0, 0, 6);
    check("abort_segs_hold", 32'({seg_4, seg_3, seg_2, seg_1}), 32'h0FFF_FFFF);

    for (int t = 0; t < 24; t++) begin
      conv($urandom_range(0, 4095), ($urandom_range(0, 3) == 0), 0, 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
